// File: rtl/rect_fill_writer_if.sv
// Bus between an upstream command source and the rectangle fill writer.
// Command handshake: a command (i_x0..i_colour) transfers on a rising edge
// where i_cmd_valid and o_cmd_ready are both high. The source may hold
// i_cmd_valid high for as long as it likes; fields are only sampled on that edge.
// The write side is a plain strobe: o_write_addr/o_data are meaningful only
// while o_write is high, and they hold their last values otherwise.
interface rect_fill_writer_if #(
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 8,
  parameter int COORD_WIDTH = 9
);
  logic                   i_cmd_valid;
  logic                   o_cmd_ready;
  logic [COORD_WIDTH-1:0] i_x0;
  logic [COORD_WIDTH-1:0] i_x1;
  logic [COORD_WIDTH-1:0] i_y0;
  logic [COORD_WIDTH-1:0] i_y1;
  logic [DATA_WIDTH-1:0]  i_colour;
  logic                   i_pause;
  logic                   o_write;
  logic [ADDR_WIDTH-1:0]  o_write_addr;
  logic [DATA_WIDTH-1:0]  o_data;
  logic                   o_busy;
  logic                   o_done;

  // Command source / SRAM side
  modport master (
    output i_cmd_valid, i_x0, i_x1, i_y0, i_y1, i_colour, i_pause,
    input  o_cmd_ready, o_write, o_write_addr, o_data, o_busy, o_done
  );

  // Fill writer side
  modport slave (
    input  i_cmd_valid, i_x0, i_x1, i_y0, i_y1, i_colour, i_pause,
    output o_cmd_ready, o_write, o_write_addr, o_data, o_busy, o_done
  );
endinterface

// File: rtl/rect_fill_writer.sv
// Rectangle fill writer: accepts one fill command, clips it to the screen and
// sweeps the clipped area in raster order, issuing one SRAM pixel write per
// unpaused cycle. All outputs are registered.
module rect_fill_writer #(
  parameter int ADDR_WIDTH    = 17,
  parameter int DATA_WIDTH    = 8,
  parameter int COORD_WIDTH   = 9,
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 240
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  rect_fill_writer_if.slave  bus,
  output logic [1:0]         o_state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_FILL  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q;
  logic [COORD_WIDTH-1:0] cx0_q, cx1_q, cy0_q, cy1_q;
  logic [DATA_WIDTH-1:0]  colour_q;
  logic [COORD_WIDTH-1:0] xmin_q, xmax_q, ymax_q;
  logic [COORD_WIDTH-1:0] x_q, y_q;
  logic [ADDR_WIDTH-1:0]  row_base_q;
  logic                   write_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   done_q;
  logic                   ready_q;
  logic                   busy_q;

  logic [COORD_WIDTH-1:0] xmin_d, xmax_d, ymin_d, ymax_d;
  logic [COORD_WIDTH-1:0] xmax_raw, ymax_raw;
  logic [ADDR_WIDTH-1:0]  row_base_d;
  logic                   offscreen_d;

  // Corner ordering, off-screen detection and clamping, used in SETUP
  always_comb begin
    xmin_d      = (cx0_q < cx1_q) ? cx0_q : cx1_q;
    xmax_raw    = (cx0_q < cx1_q) ? cx1_q : cx0_q;
    ymin_d      = (cy0_q < cy1_q) ? cy0_q : cy1_q;
    ymax_raw    = (cy0_q < cy1_q) ? cy1_q : cy0_q;
    offscreen_d = (int'(xmin_d) >= SCREEN_WIDTH) || (int'(ymin_d) >= SCREEN_HEIGHT);
    xmax_d      = (int'(xmax_raw) > SCREEN_WIDTH - 1) ?
                  COORD_WIDTH'(SCREEN_WIDTH - 1) : xmax_raw;
    ymax_d      = (int'(ymax_raw) > SCREEN_HEIGHT - 1) ?
                  COORD_WIDTH'(SCREEN_HEIGHT - 1) : ymax_raw;
    row_base_d  = ADDR_WIDTH'(ymin_d) * ADDR_WIDTH'(SCREEN_WIDTH);
  end

  // Control FSM with registered write, handshake and status outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cx0_q      <= '0;
      cx1_q      <= '0;
      cy0_q      <= '0;
      cy1_q      <= '0;
      colour_q   <= '0;
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymax_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      write_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.i_cmd_valid) begin
            cx0_q    <= bus.i_x0;
            cx1_q    <= bus.i_x1;
            cy0_q    <= bus.i_y0;
            cy1_q    <= bus.i_y1;
            colour_q <= bus.i_colour;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_SETUP;
          end
        end
        S_SETUP: begin
          xmin_q     <= xmin_d;
          xmax_q     <= xmax_d;
          ymax_q     <= ymax_d;
          x_q        <= xmin_d;
          y_q        <= ymin_d;
          row_base_q <= row_base_d;
          state_q    <= offscreen_d ? S_DONE : S_FILL;
        end
        S_FILL: begin
          // A paused cycle issues nothing and leaves the sweep position alone
          if (!bus.i_pause) begin
            write_q <= 1'b1;
            addr_q  <= row_base_q + ADDR_WIDTH'(x_q);
            data_q  <= colour_q;
            if (x_q == xmax_q) begin
              if (y_q == ymax_q) begin
                state_q <= S_DONE;
              end else begin
                x_q        <= xmin_q;
                y_q        <= y_q + COORD_WIDTH'(1);
                row_base_q <= row_base_q + ADDR_WIDTH'(SCREEN_WIDTH);
              end
            end else begin
              x_q <= x_q + COORD_WIDTH'(1);
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_cmd_ready  = ready_q;
  assign bus.o_write      = write_q;
  assign bus.o_write_addr = addr_q;
  assign bus.o_data       = data_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign o_state_dbg      = state_q;

endmodule
